writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Producer side of the register-file write port. Accepts results from the ALU and load channels and queues them in a DEPTH-entry FIFO. Drains one entry per cycle onto the register file's write port (A3/D3/IsWb). Exposes pending-write forwarding and a busy mask to operand fetch.

Parameters:
DEPTH, 4, write-queue entries; power of two, >= 2
AW, 4, register address width (16 registers)
DW, 32, data width

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-low reset
AluValid  input  1  ALU result valid
AluRd  input  AW  ALU destination register
AluData  input  DW  ALU result
AluReady  output  1  ALU result accepted this cycle when AluValid=1
LdValid  input  1  load result valid
LdRd  input  AW  load destination register
LdData  input  DW  load data
LdReady  output  1  load result accepted this cycle when LdValid=1
Stall  input  1  1 = hold drain; no register-file write this cycle
A3  output  AW  register-file write address (registered)
D3  output  DW  register-file write data (registered)
IsWb  output  1  register-file write strobe; one cycle per write (registered)
RdA1  input  AW  forwarding query 1 (operand fetch A1)
Hit1  output  1  pending write to RdA1 exists
Fwd1  output  DW  youngest pending data for RdA1; 0 when Hit1=0
RdA2  input  AW  forwarding query 2 (operand fetch A2)
Hit2  output  1  pending write to RdA2 exists
Fwd2  output  DW  youngest pending data for RdA2; 0 when Hit2=0
PendMask  output  16  bit r = 1 while any queued or output-stage write targets r

Behaviour:
- Reset low, asynchronously: count, read and write pointers = 0; IsWb=0, A3=0, D3=0; all queue entries invalid; AluReady=LdReady=0; PendMask=0; Hit1/Hit2=0, Fwd1/Fwd2=0.
- Reset mid-operation discards all queued and output-stage writes. Nothing is emitted after release.
- full = (count==DEPTH), computed from the registered count. An entry drained in the same cycle does not free a slot that cycle.
- Enqueue: at most one per cycle, fixed priority load over ALU.
  - LdReady = !full.
  - AluReady = !full && !LdValid.
  - A handshake completes when Valid && Ready at the rising edge. The entry {rd, data} is written at wptr, and wptr wraps modulo DEPTH.
- Drain: at each rising edge with Stall=0 and count>0, the head is moved into the output register: A3<=rd, D3<=data, IsWb<=1, rptr wraps modulo DEPTH.
  - Otherwise IsWb<=0; A3/D3 hold their last value.
- The register file commits at the edge after IsWb rises. Minimum latency from input handshake edge to IsWb high is 1 cycle.
- Simultaneous enqueue and drain: count unchanged, both pointers advance. Order is strictly FIFO across both sources.
- Forwarding (combinational from state only; a same-cycle input handshake is not forwarded):
  - Search queue entries newest to oldest, then the output stage (while IsWb=1).
  - The first match supplies Fwd. This gives the youngest-wins rule for repeated writes to one register.
- PendMask is the OR of one-hot(rd) over valid entries plus the output stage when IsWb=1.
- No special register: writes to R0, R14 and R15 pass through unchanged.

Decomposition:
- Package wb_pkg: AW, DW, NREGS=16, DEPTH default, and entry typedef {rd[AW], data[DW]}.
- Sub-module wb_fifo: synchronous FIFO with push, pop, full, empty, count, and flat entry/valid vectors for the forwarding search.
- Arbitration, output register, forwarding and PendMask stay in writeback_unit.

Test Plan:
1. After reset, one ALU handshake {Rd=3, 0xDEADBEEF}, Stall=0 -> next cycle IsWb=1, A3=3, D3=0xDEADBEEF for exactly one cycle; AluReady=1 throughout.
2. Same cycle LdValid {5, 0x11} and AluValid {6, 0x22} -> LdReady=1, AluReady=0. ALU accepted the following cycle. IsWb sequence is (5, 0x11) then (6, 0x22) on consecutive cycles.
3. Stall=1, push 4 ALU entries to R1..R4 -> LdReady=AluReady=0 after the 4th; PendMask=0x001E. Release Stall -> four back-to-back IsWb in order R1..R4; PendMask reaches 0 one cycle after the last.
4. Stall=1, push {7, 0xA} then {7, 0xB}; RdA1=7, RdA2=8 -> Hit1=1, Fwd1=0xB, Hit2=0, Fwd2=0.
5. Stall=1, 3 entries queued, drop Reset between edges -> IsWb, PendMask and count go to 0 immediately. After release with Stall=0, IsWb stays 0.
6. 10 writes with alternating Stall to wrap pointers past DEPTH twice -> all 10 emitted exactly once, in order, with correct data.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int unsigned AW            = 4;
  localparam int unsigned DW            = 32;
  localparam int unsigned NREGS         = 16;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // One-hot register select, used to build the pending-write mask.
  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] r);
    logic [NREGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Result channels, register-file write port and forwarding query bus.
interface wb_if;
  import wb_pkg::*;

  logic             AluValid;
  logic [AW-1:0]    AluRd;
  logic [DW-1:0]    AluData;
  logic             AluReady;
  logic             LdValid;
  logic [AW-1:0]    LdRd;
  logic [DW-1:0]    LdData;
  logic             LdReady;
  logic             Stall;
  logic [AW-1:0]    A3;
  logic [DW-1:0]    D3;
  logic             IsWb;
  logic [AW-1:0]    RdA1;
  logic             Hit1;
  logic [DW-1:0]    Fwd1;
  logic [AW-1:0]    RdA2;
  logic             Hit2;
  logic [DW-1:0]    Fwd2;
  logic [NREGS-1:0] PendMask;

  // Writeback unit side
  modport slave (
    input  AluValid, AluRd, AluData, LdValid, LdRd, LdData, Stall, RdA1, RdA2,
    output AluReady, LdReady, A3, D3, IsWb, Hit1, Fwd1, Hit2, Fwd2, PendMask
  );

  // Producer / register-file / operand-fetch side
  modport master (
    output AluValid, AluRd, AluData, LdValid, LdRd, LdData, Stall, RdA1, RdA2,
    input  AluReady, LdReady, A3, D3, IsWb, Hit1, Fwd1, Hit2, Fwd2, PendMask
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous write queue; exposes all slots for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output entry_t                  head,
  output logic                    full,
  output logic                    empty,
  output logic [PW:0]             count,
  output logic [PW-1:0]           rptr,
  output entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]        valids
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointer, occupancy and slot-valid bookkeeping
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      valids <= '0;
    end else begin
      if (do_push) begin
        valids[wptr] <= 1'b1;
        wptr         <= wptr + PW'(1);
      end
      if (do_pop) begin
        valids[rptr] <= 1'b0;
        rptr         <= rptr + PW'(1);
      end
      if (do_push && !do_pop)
        count <= count + (PW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (PW+1)'(1);
    end
  end

  // Entry storage; contents are qualified by the valid bits
  always_ff @(posedge Clk) begin
    if (do_push)
      mem[wptr] <= push_entry;
  end

  // Present every slot for the forwarding search
  always_comb begin
    entries = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      entries[i] = mem[i];
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: arbitrates ALU/load results into a
// FIFO, drains one per cycle, and provides forwarding plus a busy mask.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input logic  Clk,
  input logic  Reset,
  wb_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic               full;
  logic               empty;
  logic [PW:0]        count;
  logic [PW-1:0]      rptr;
  entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]   valids;
  entry_t             head;
  logic               push;
  logic               pop;
  entry_t             push_entry;

  logic               wb_v;
  logic [AW-1:0]      wb_rd;
  logic [DW-1:0]      wb_data;

  logic               hit1;
  logic               hit2;
  logic [DW-1:0]      fwd1;
  logic [DW-1:0]      fwd2;
  logic [NREGS-1:0]   pend;
  logic [PW-1:0]      idx;
  entry_t             e;

  // Load has fixed priority over ALU; readies held low during reset
  assign bus.LdReady  = Reset && !full;
  assign bus.AluReady = Reset && !full && !bus.LdValid;
  assign push         = (bus.LdValid && bus.LdReady) || (bus.AluValid && bus.AluReady);
  assign push_entry   = bus.LdValid ? entry_t'{rd: bus.LdRd,  data: bus.LdData}
                                    : entry_t'{rd: bus.AluRd, data: bus.AluData};
  assign pop          = !bus.Stall && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .rptr       (rptr),
    .entries    (entries),
    .valids     (valids)
  );

  // Output stage: one register-file write strobe per drained entry
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wb_v    <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (pop) begin
      wb_v    <= 1'b1;
      wb_rd   <= head.rd;
      wb_data <= head.data;
    end else begin
      wb_v    <= 1'b0;
    end
  end

  assign bus.IsWb = wb_v;
  assign bus.A3   = wb_rd;
  assign bus.D3   = wb_data;

  // Forwarding and pending mask from registered state only.
  // Output stage is applied first, then queue entries oldest to newest so a
  // later match overwrites: equivalent to a newest-first, first-hit search.
  always_comb begin
    hit1 = 1'b0;
    fwd1 = '0;
    hit2 = 1'b0;
    fwd2 = '0;
    pend = '0;
    idx  = '0;
    e    = '0;
    if (wb_v) begin
      pend = onehot(wb_rd);
      if (wb_rd == bus.RdA1) begin
        hit1 = 1'b1;
        fwd1 = wb_data;
      end
      if (wb_rd == bus.RdA2) begin
        hit2 = 1'b1;
        fwd2 = wb_data;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      e   = entries[idx];
      if (i < 32'(count)) begin
        if (e.rd == bus.RdA1) begin
          hit1 = 1'b1;
          fwd1 = e.data;
        end
        if (e.rd == bus.RdA2) begin
          hit2 = 1'b1;
          fwd2 = e.data;
        end
      end
      if (valids[PW'(i)])
        pend = pend | onehot(entries[PW'(i)].rd);
    end
  end

  assign bus.Hit1     = hit1;
  assign bus.Fwd1     = fwd1;
  assign bus.Hit2     = hit2;
  assign bus.Fwd2     = fwd2;
  assign bus.PendMask = pend;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit with a queue-based reference model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  wb_if bus();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t mq[$];     // model: writes accepted but not yet drained
  wr_t exp_q[$];  // scoreboard: every accepted write, in emission order
  bit  out_v;
  wr_t out_s;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_pend();
    logic [15:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (out_v) m[out_s.rd] = 1'b1;
    return m;
  endfunction

  function automatic void m_fwd(input logic [3:0] q, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].rd == q) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
    if (out_v && out_s.rd == q) begin
      h = 1'b1;
      d = out_s.d;
    end
  endfunction

  // One clock: drive, check combinational/registered outputs, advance model
  task automatic step(input bit lv, input logic [3:0] lrd, input logic [31:0] ld,
                      input bit av, input logic [3:0] ard, input logic [31:0] ad,
                      input bit st);
    bit          full;
    logic        h;
    logic [31:0] d;
    wr_t         w;
    bus.LdValid  = lv;  bus.LdRd  = lrd; bus.LdData  = ld;
    bus.AluValid = av;  bus.AluRd = ard; bus.AluData = ad;
    bus.Stall    = st;
    bus.RdA1     = 4'($urandom_range(0, 15));
    bus.RdA2     = 4'($urandom_range(0, 15));
    @(negedge Clk);
    full = (mq.size() == DEPTH);
    chk("ld_ready",  bus.LdReady,  !full);
    chk("alu_ready", bus.AluReady, !full && !lv);
    chk("iswb",      bus.IsWb,     out_v);
    chk("pendmask",  bus.PendMask, m_pend());
    m_fwd(bus.RdA1, h, d);
    chk("hit1", bus.Hit1, h);
    chk("fwd1", bus.Fwd1, d);
    m_fwd(bus.RdA2, h, d);
    chk("hit2", bus.Hit2, h);
    chk("fwd2", bus.Fwd2, d);
    @(posedge Clk);
    if (!st && mq.size() > 0) begin
      out_s = mq.pop_front();
      out_v = 1'b1;
    end else begin
      out_v = 1'b0;
    end
    if (!full && (lv || av)) begin
      w.rd = lv ? lrd : ard;
      w.d  = lv ? ld  : ad;
      mq.push_back(w);
      exp_q.push_back(w);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation
  always @(negedge Clk) begin
    wr_t e;
    if (Reset === 1'b1 && bus.IsWb === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_extra", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_a3", bus.A3, e.rd);
        chk("wb_d3", bus.D3, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b0;
    bus.LdValid  = 0; bus.LdRd  = '0; bus.LdData  = '0;
    bus.AluValid = 0; bus.AluRd = '0; bus.AluData = '0;
    bus.Stall    = 0; bus.RdA1  = '0; bus.RdA2    = '0;
    out_v        = 0;
    #2;
    chk("rst_iswb",  bus.IsWb,     0);
    chk("rst_a3",    bus.A3,       0);
    chk("rst_d3",    bus.D3,       0);
    chk("rst_pend",  bus.PendMask, 0);
    chk("rst_ldrdy", bus.LdReady,  0);
    chk("rst_alrdy", bus.AluReady, 0);
    chk("rst_hit1",  bus.Hit1,     0);
    chk("rst_fwd1",  bus.Fwd1,     0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // Single ALU write, one-cycle latency
    step(0, 4'd0, 32'd0, 1, 4'd3, 32'hDEADBEEF, 0);
    step(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
    chk("t1_iswb", bus.IsWb, 1);
    chk("t1_a3",   bus.A3,   3);
    chk("t1_d3",   bus.D3,   32'hDEADBEEF);
    idle(2);

    // Load wins a simultaneous request; ALU follows next cycle
    step(1, 4'd5, 32'h11, 1, 4'd6, 32'h22, 0);
    step(0, 4'd0, 32'd0,  1, 4'd6, 32'h22, 0);
    idle(3);

    // Fill under stall, reject when full, then drain back-to-back
    for (int r = 1; r <= 4; r++) step(0, 4'd0, 32'd0, 1, 4'(r), $urandom, 1);
    chk("t3_pend", bus.PendMask, 16'h001E);
    step(1, 4'd9, 32'h99, 1, 4'd9, 32'h99, 1);
    idle(6);

    // Youngest-wins forwarding on a repeated destination
    step(0, 4'd0, 32'd0, 1, 4'd7, 32'hA, 1);
    step(0, 4'd0, 32'd0, 1, 4'd7, 32'hB, 1);
    bus.RdA1 = 4'd7;
    bus.RdA2 = 4'd8;
    #1;
    chk("t4_hit1", bus.Hit1, 1);
    chk("t4_fwd1", bus.Fwd1, 32'hB);
    chk("t4_hit2", bus.Hit2, 0);
    chk("t4_fwd2", bus.Fwd2, 0);
    idle(4);

    // Asynchronous reset with writes queued discards everything
    for (int r = 1; r <= 3; r++) step(0, 4'd0, 32'd0, 1, 4'(r), $urandom, 1);
    bus.AluValid = 0;
    bus.LdValid  = 0;
    bus.RdA1     = 4'd1;
    #2;
    Reset = 1'b0;
    #1;
    chk("t5_iswb",  bus.IsWb,     0);
    chk("t5_pend",  bus.PendMask, 0);
    chk("t5_hit1",  bus.Hit1,     0);
    chk("t5_ldrdy", bus.LdReady,  0);
    mq.delete();
    exp_q.delete();
    out_v = 0;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    idle(5);

    // Ten writes with alternating stall to wrap the pointers
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(0, 4'd0, 32'd0, 1, 4'(i / 2), $urandom, 1);
      else            step(0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 0);
    end
    idle(3);

    // Randomized traffic
    repeat (400) begin
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 3);
    end
    idle(2 * DEPTH + 4);
    chk("drain_all", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
